fetch_pc_sequencer: RTL
=======================

Name: fetch_pc_sequencer

Overview:
- Consumer end of the branch/jump target path: owns the architectural fetch PC and drives the instruction-memory request.
- Accepts a redirect (Request_Alt_PC / Alt_PC) from decode, where NextInstructionAddress is produced.
- Applies MIPS single-delay-slot semantics.
- Delivers fetched words, with Instr_PC and Instr_PC_Plus4, to the IF/ID boundary; honours decode stall through a one-entry skid buffer.

Parameters:
- RESET_PC, 32'hBFC00000, first fetch address after reset.
- PC_INC, 4, sequential increment in bytes.

Ports:
- CLOCK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  decode cannot accept a new instruction this cycle.
- Request_Alt_PC  in  1  single-cycle pulse: the branch/jump now in decode is taken.
- Alt_PC  in  32  redirect target, valid with Request_Alt_PC.
- IMem_Req  out  1  fetch request.
- IMem_Addr  out  32  fetch address; stable while IMem_Req=1 until ack.
- IMem_Ack  in  1  memory returns IMem_Data this cycle; may be same-cycle (zero-wait).
- IMem_Data  in  32  fetched word.
- Instr  out  32  instruction to decode.
- Instr_PC  out  32  address of Instr.
- Instr_PC_Plus4  out  32  Instr_PC + 4, registered.
- Instr_Valid  out  1  Instr holds a real instruction.

Behaviour:
- Reset (synchronous, sampled at the edge):
  - state <= BOOT; Fetch_PC <= RESET_PC; pending <= 0; skid_valid <= 0.
  - Instr, Instr_PC, Instr_PC_Plus4 <= 0; Instr_Valid <= 0.
  - IMem_Req = 0 while RESET=1.
  - Reset mid-request abandons the outstanding fetch; its late ack is ignored.
- advance = !STALL || !Instr_Valid. The output register loads only when advance=1.
- States:
  - BOOT: Req=0 for exactly one cycle; next state FETCH.
  - FETCH: Req=1, IMem_Addr=Fetch_PC. No ack: stay. Ack with advance: output <= {IMem_Data, Fetch_PC, Fetch_PC+4, valid=1}, Fetch_PC <= next_pc, stay. Ack without advance: skid <= {IMem_Data, Fetch_PC}, Fetch_PC <= next_pc, go to HOLD.
  - HOLD: Req=0. When advance: output <= skid, skid_valid <= 0, go to FETCH.
- If FETCH has no ack and advance=1, Instr_Valid <= 0 (bubble).
- Instr_Valid stays 1 under STALL; outputs are held bit-exact.
- next_pc:
  - Request_Alt_PC on the same edge: {Alt_PC[31:2], 2'b00} (bypass).
  - Else if pending: Redirect_PC.
  - Else: Fetch_PC + PC_INC, wrapping modulo 2^32.
- Delay slot: a redirect never cancels the fetch that is outstanding or buffered; that fetch is the delay slot. The target is the next address issued.
- Redirect capture:
  - Request_Alt_PC is sampled in FETCH and HOLD, ignored in BOOT and reset.
  - If not consumed on the same edge (no ack in FETCH, or state HOLD): Redirect_PC <= {Alt_PC[31:2], 2'b00}, pending <= 1.
  - pending clears on the edge where next_pc is consumed.
  - Second redirect while pending: last wins.
- Latency with zero-wait memory:
  - One instruction per cycle.
  - First Instr_Valid=1 is visible two edges after RESET deasserts (BOOT edge, then FETCH/ack edge).
- Alignment: Alt_PC[1:0] is ignored; Fetch_PC[1:0] is always 00.

Decomposition:
- Shared constants header alongside config.v holds:
  - state encodings BOOT/FETCH/HOLD (2-bit);
  - RESET_PC default;
  - PC_INC;
  - NOP word 32'h0.
- One sub-module: fetch_skid_buffer, a one-entry {data, pc} register with load/unload/valid.
- Remaining RTL: FSM, PC/redirect logic, output register.

Test Plan:
- Reset release, zero-wait memory returning addr^32'hFFFFFFFF -> Req low for 1 cycle, then IMem_Addr BFC00000, BFC00004, BFC00008 on consecutive cycles; Instr_PC_Plus4 = Instr_PC+4.
- Branch at BFC00004 in decode, Request_Alt_PC=1, Alt_PC=BFC00100, zero-wait -> fetches BFC00008 (delay slot), then BFC00100, BFC00104.
- Memory acks after 3 cycles; redirect pulse (Alt_PC=00400003) arrives in wait cycle 1 -> IMem_Addr held until ack; next request 00400000; pending cleared.
- STALL=1 for 4 cycles while the FETCH ack lands -> Instr held, word parked in skid, Req=0 in HOLD; on STALL drop the skid word is output next cycle; no word lost or duplicated.
- Fetch_PC=FFFFFFFC, no redirect -> next IMem_Addr 00000000.
- RESET asserted mid-wait with ack arriving in the same cycle -> no Instr_Valid; the sequence restarts at BOOT then BFC00000.

Source files
------------

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared constants for the fetch PC sequencer: FSM encodings, reset vector,
// sequential increment and the NOP word.
package fetch_pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {data, pc} parking register used when decode stalls while a
// fetch ack lands.
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pc,
  output logic [31:0] o_data,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_data;
  logic [31:0] r_pc;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  // Payload carries no reset: it is only observed while r_valid is set.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_data <= i_data;
      r_pc   <= i_pc;
    end
  end

  assign o_data  = r_data;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Owns the architectural fetch PC, issues instruction-memory requests and
// delivers fetched words to IF/ID with single-delay-slot redirect semantics.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        Request_Alt_PC,
  input  logic [31:0] Alt_PC,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Data,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic [31:0] Instr_PC_Plus4,
  output logic        Instr_Valid
);

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_redirect_pc;
  logic         r_pending;

  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic [31:0]  r_instr_pc4;
  logic         r_instr_valid;

  logic         w_advance;
  logic         w_in_fetch;
  logic         w_in_hold;
  logic         w_ack;
  logic [31:0]  w_alt_pc;
  logic [31:0]  w_next_pc;
  logic         w_skid_load;
  logic         w_skid_unload;
  logic [31:0]  w_skid_data;
  logic [31:0]  w_skid_pc;
  logic         w_skid_valid;

  assign w_advance  = !STALL || !r_instr_valid;
  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_in_hold  = (r_state == ST_HOLD);
  assign w_ack      = w_in_fetch && IMem_Ack;
  assign w_alt_pc   = align_word(Alt_PC);

  // A redirect arriving on the consuming edge bypasses the pending register.
  assign w_next_pc = Request_Alt_PC ? w_alt_pc :
                     r_pending      ? r_redirect_pc :
                                      (r_fetch_pc + PC_INC);

  assign w_skid_load   = w_ack && !w_advance;
  assign w_skid_unload = w_in_hold && w_advance;

  assign IMem_Req  = w_in_fetch && !RESET;
  assign IMem_Addr = r_fetch_pc;

  fetch_skid_buffer u_skid (
    .clk      (CLOCK),
    .rst      (RESET),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_data   (IMem_Data),
    .i_pc     (r_fetch_pc),
    .o_data   (w_skid_data),
    .o_pc     (w_skid_pc),
    .o_valid  (w_skid_valid)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= align_word(RESET_PC);
      r_pending     <= 1'b0;
      r_instr       <= NOP_WORD;
      r_instr_pc    <= 32'h0;
      r_instr_pc4   <= 32'h0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_FETCH;
        end

        ST_FETCH: begin
          if (IMem_Ack) begin
            // The acked word is the delay slot; the redirect (if any) is
            // consumed here as the next fetch address.
            r_fetch_pc <= w_next_pc;
            r_pending  <= 1'b0;
            if (w_advance) begin
              r_instr       <= IMem_Data;
              r_instr_pc    <= r_fetch_pc;
              r_instr_pc4   <= r_fetch_pc + WORD_BYTES;
              r_instr_valid <= 1'b1;
            end else begin
              r_state <= ST_HOLD;
            end
          end else begin
            if (w_advance) begin
              r_instr_valid <= 1'b0;
            end
            if (Request_Alt_PC) begin
              r_redirect_pc <= w_alt_pc;
              r_pending     <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (Request_Alt_PC) begin
            r_redirect_pc <= w_alt_pc;
            r_pending     <= 1'b1;
          end
          if (w_advance) begin
            r_instr       <= w_skid_data;
            r_instr_pc    <= w_skid_pc;
            r_instr_pc4   <= w_skid_pc + WORD_BYTES;
            r_instr_valid <= w_skid_valid;
            r_state       <= ST_FETCH;
          end
        end

        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign Instr          = r_instr;
  assign Instr_PC       = r_instr_pc;
  assign Instr_PC_Plus4 = r_instr_pc4;
  assign Instr_Valid    = r_instr_valid;

endmodule
